// File: rtl/uart_alu_ctrl.sv
// Packet sequencer between UART byte streams and a shared multi-cycle ALU.
// Parses a 4-byte header, then echoes the payload, drains a malformed
// packet, or folds 32-bit little-endian operands through the ALU and
// returns the 4-byte result.
//
// state      | meaning
// S_IDLE     | waiting for opcode byte
// S_HDR_RSV  | waiting for reserved byte
// S_HDR_LEN_LO | waiting for LEN[7:0]
// S_HDR_LEN_HI | waiting for LEN[15:8], command validated on accept
// S_DRAIN    | discarding the rest of a malformed packet
// S_ECHO     | payload forwarded RX -> TX combinationally
// S_OPND     | collecting 4 operand bytes, LSB first
// S_ALU_START| one-cycle start pulse to the ALU
// S_ALU_WAIT | operands held until alu_done_i
// S_TX_RES   | sending accumulator bytes, LSB first
module uart_alu_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_start_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [7:0] OpEcho = 8'hEC;
  localparam logic [7:0] OpAdd  = 8'hAD;
  localparam logic [7:0] OpMul  = 8'h8C;
  localparam logic [7:0] OpDiv  = 8'h4D;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_RSV, S_HDR_LEN_LO, S_HDR_LEN_HI, S_DRAIN,
    S_ECHO, S_OPND, S_ALU_START, S_ALU_WAIT, S_TX_RES
  } state_t;

  state_t      state;
  logic [7:0]  opcode;
  logic [7:0]  len_lo;
  logic [15:0] remaining;
  logic [1:0]  byte_cnt;
  logic [1:0]  tx_cnt;
  logic        first_opnd;
  logic [31:0] opnd;
  logic [31:0] acc;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic [15:0] len_full;
  logic [31:0] opnd_full;
  logic        rx_acc;
  logic        tx_acc;
  logic        hdr_bad;
  logic [1:0]  op_sel;

  assign len_full  = {rx_data_i, len_lo};
  assign opnd_full = {rx_data_i, opnd[31:8]};
  assign rx_acc    = rx_valid_i & rx_ready_o;
  assign tx_acc    = tx_valid_o & tx_ready_i;
  assign busy_o    = (state != S_IDLE);

  // ECHO bypasses the TX registers; everywhere else TX is registered
  always_comb begin
    rx_ready_o = 1'b0;
    tx_data_o  = tx_data_q;
    tx_valid_o = tx_valid_q;
    case (state)
      S_IDLE, S_HDR_RSV, S_HDR_LEN_LO, S_HDR_LEN_HI,
      S_DRAIN, S_OPND: rx_ready_o = 1'b1;
      S_ECHO: begin
        rx_ready_o = tx_ready_i;
        tx_data_o  = rx_data_i;
        tx_valid_o = rx_valid_i;
      end
      default: rx_ready_o = 1'b0;
    endcase
  end

  // Header validation (LEN >= 4 is checked separately) and ALU op mapping
  always_comb begin
    hdr_bad = 1'b1;
    op_sel  = 2'd0;
    case (opcode)
      OpEcho: hdr_bad = 1'b0;
      OpAdd: hdr_bad = (len_full < 16'd8) || (len_full[1:0] != 2'd0);
      OpMul: begin
        hdr_bad = (len_full < 16'd8) || (len_full[1:0] != 2'd0);
        op_sel  = 2'd1;
      end
      OpDiv: begin
        hdr_bad = (len_full != 16'd12);
        op_sel  = 2'd2;
      end
      default: hdr_bad = 1'b1;
    endcase
  end

  // Packet sequencer with registered TX, ALU and error outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      opcode      <= 8'd0;
      len_lo      <= 8'd0;
      remaining   <= 16'd0;
      byte_cnt    <= 2'd0;
      tx_cnt      <= 2'd0;
      first_opnd  <= 1'b0;
      opnd        <= 32'd0;
      acc         <= 32'd0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      alu_op_o    <= 2'd0;
      alu_a_o     <= 32'd0;
      alu_b_o     <= 32'd0;
      alu_start_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o       <= 1'b0;
      alu_start_o <= 1'b0;
      case (state)
        S_IDLE: if (rx_acc) begin
          opcode <= rx_data_i;
          state  <= S_HDR_RSV;
        end
        S_HDR_RSV: if (rx_acc) state <= S_HDR_LEN_LO;
        S_HDR_LEN_LO: if (rx_acc) begin
          len_lo <= rx_data_i;
          state  <= S_HDR_LEN_HI;
        end
        S_HDR_LEN_HI: if (rx_acc) begin
          byte_cnt   <= 2'd0;
          first_opnd <= 1'b1;
          remaining  <= len_full - 16'd4;
          if (len_full < 16'd4) begin
            err_o     <= 1'b1;
            remaining <= 16'd0;
            state     <= S_IDLE;
          end else if (hdr_bad) begin
            err_o <= 1'b1;
            state <= (len_full == 16'd4) ? S_IDLE : S_DRAIN;
          end else if (opcode == OpEcho) begin
            state <= (len_full == 16'd4) ? S_IDLE : S_ECHO;
          end else begin
            state <= S_OPND;
          end
        end
        S_DRAIN, S_ECHO: if (rx_acc) begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= S_IDLE;
        end
        S_OPND: if (rx_acc) begin
          remaining <= remaining - 16'd1;
          byte_cnt  <= byte_cnt + 2'd1;
          opnd      <= opnd_full;
          if (byte_cnt == 2'd3) begin
            if (first_opnd) begin
              first_opnd <= 1'b0;
              acc        <= opnd_full;
              if (remaining == 16'd1) begin
                tx_cnt     <= 2'd0;
                tx_data_q  <= opnd_full[7:0];
                tx_valid_q <= 1'b1;
                state      <= S_TX_RES;
              end
            end else begin
              alu_a_o     <= acc;
              alu_b_o     <= opnd_full;
              alu_op_o    <= op_sel;
              alu_start_o <= 1'b1;
              state       <= S_ALU_START;
            end
          end
        end
        S_ALU_START: state <= S_ALU_WAIT;
        S_ALU_WAIT: if (alu_done_i) begin
          acc <= alu_result_i;
          if (remaining == 16'd0) begin
            tx_cnt     <= 2'd0;
            tx_data_q  <= alu_result_i[7:0];
            tx_valid_q <= 1'b1;
            state      <= S_TX_RES;
          end else begin
            state <= S_OPND;
          end
        end
        S_TX_RES: if (tx_acc) begin
          if (tx_cnt == 2'd3) begin
            tx_valid_q <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 2'd1;
            case (tx_cnt)
              2'd0:    tx_data_q <= acc[15:8];
              2'd1:    tx_data_q <= acc[23:16];
              default: tx_data_q <= acc[31:24];
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized bench for uart_alu_ctrl with a packet-level reference model
// and a behavioural ALU responder.
`timescale 1ns/1ps
module tb_uart_alu_ctrl;

  typedef logic [7:0]  byte_t;
  typedef byte_t       byte_q[$];
  typedef logic [31:0] word_q[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready = 1'b1;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_start_o;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic        err_o, busy_o;

  int errors = 0;
  int checks = 0;

  uart_alu_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_start_o(alu_start_o), .alu_done_i(alu_done), .alu_result_i(alu_result),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  // monitors: TX transfers, stall stability, pulse counts
  byte_t got_tx[$];
  int    err_seen, start_seen, hold_bad;
  logic  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!tx_valid_o || tx_data_o !== prev_data)) hold_bad++;
      if (tx_valid_o && tx_ready) got_tx.push_back(tx_data_o);
      prev_stall = tx_valid_o && !tx_ready;
      prev_data  = tx_data_o;
      if (err_o) err_seen++;
      if (alu_start_o) start_seen++;
    end
  end

  // ALU responder
  word_q log_a, log_b, log_op;
  int    alu_delay_fix = 0;
  logic  rst_event = 1'b0;

  always begin
    logic [31:0] a, b;
    logic [1:0]  op;
    int d;
    @(negedge clk);
    if (rst_n && alu_start_o) begin
      a = alu_a_o; b = alu_b_o; op = alu_op_o;
      log_a.push_back(a); log_b.push_back(b); log_op.push_back({30'd0, op});
      rst_event = 1'b0;
      d = (alu_delay_fix != 0) ? alu_delay_fix : int'($urandom_range(1, 6));
      repeat (d) @(posedge clk);
      #1;
      alu_done = 1'b1;
      alu_result = alu_model(a, b, op);
      @(negedge clk);
      if (!rst_event && (alu_a_o !== a || alu_b_o !== b || alu_op_o !== op)) hold_bad++;
      @(posedge clk); #1;
      alu_done = 1'b0;
    end
  end

  // TX ready driver: 0 = always ready, 1 = random, 2 = toggle
  int tx_mode = 0;
  int tx_low = 0;
  always begin
    @(posedge clk); #1;
    if (tx_low > 0) begin
      tx_ready = 1'b0;
      tx_low--;
    end else begin
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = !tx_ready;
      endcase
    end
  end

  // reference: expected TX bytes, error pulses and ALU operations of a packet
  task automatic model_pkt(input byte_q p, output byte_q etx, output int eerr,
                           output word_q ea, output word_q eb, output word_q eop);
    int len;
    int n;
    logic ok;
    logic [1:0] op;
    logic [31:0] acc, b;
    len = int'({p[3], p[2]});
    etx = {}; ea = {}; eb = {}; eop = {}; eerr = 0;
    ok = 1'b0; op = 2'd0;
    if (len < 4) eerr = 1;
    else if (p[0] == 8'hEC) begin
      for (int i = 4; i < len; i++) etx.push_back(p[i]);
    end else begin
      if (p[0] == 8'hAD)      begin op = 2'd0; ok = (len >= 8) && (len % 4 == 0); end
      else if (p[0] == 8'h8C) begin op = 2'd1; ok = (len >= 8) && (len % 4 == 0); end
      else if (p[0] == 8'h4D) begin op = 2'd2; ok = (len == 12); end
      if (!ok) eerr = 1;
      else begin
        n = (len - 4) / 4;
        acc = {p[7], p[6], p[5], p[4]};
        for (int k = 1; k < n; k++) begin
          b = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
          ea.push_back(acc); eb.push_back(b); eop.push_back({30'd0, op});
          acc = alu_model(acc, b, op);
        end
        for (int i = 0; i < 4; i++) etx.push_back(byte_t'(acc >> (8 * i)));
      end
    end
  endtask

  // called and returns aligned 1ns after a rising edge
  task automatic send_pkt(input byte_q p, input int stall_at);
    int w;
    for (int i = 0; i < p.size(); i++) begin
      if (i == stall_at) tx_low = 3;
      while ($urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = p[i];
      w = 0;
      @(negedge clk);
      while (!rx_ready_o && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (w >= 500) begin
        check_val("rx accept timeout", 32'(w), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_pkt(input string name, input byte_q p, input int stall_at);
    byte_q etx;
    word_q ea, eb, eop;
    int eerr, w;
    model_pkt(p, etx, eerr, ea, eb, eop);
    got_tx = {}; log_a = {}; log_b = {}; log_op = {};
    err_seen = 0; start_seen = 0; hold_bad = 0;
    send_pkt(p, stall_at);
    w = 0;
    @(negedge clk);
    while (busy_o && w < 2000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val({name, " idle"}, 32'(busy_o), 32'd0);
    check_val({name, " err"}, 32'(err_seen), 32'(eerr));
    check_val({name, " starts"}, 32'(start_seen), 32'(ea.size()));
    check_val({name, " tx count"}, 32'(got_tx.size()), 32'(etx.size()));
    for (int i = 0; i < got_tx.size() && i < etx.size(); i++)
      check_val({name, " tx byte"}, 32'(got_tx[i]), 32'(etx[i]));
    for (int i = 0; i < log_a.size() && i < ea.size(); i++) begin
      check_val({name, " alu a"}, log_a[i], ea[i]);
      check_val({name, " alu b"}, log_b[i], eb[i]);
      check_val({name, " alu op"}, log_op[i], eop[i]);
    end
    check_val({name, " hold"}, 32'(hold_bad), 32'd0);
  endtask

  function automatic byte_q rand_pkt();
    byte_q p;
    int kind, len, n;
    logic [7:0] op;
    kind = $urandom_range(0, 7);
    op = 8'hEC; len = 4;
    case (kind)
      0: begin op = 8'hEC; len = $urandom_range(4, 12); end
      1: begin op = 8'hAD; n = $urandom_range(1, 4); len = 4 + 4 * n; end
      2: begin op = 8'h8C; n = $urandom_range(1, 4); len = 4 + 4 * n; end
      3: begin op = 8'h4D; len = 12; end
      4: begin
        op = 8'($urandom_range(0, 255));
        while (op == 8'hEC || op == 8'hAD || op == 8'h8C || op == 8'h4D) op = 8'($urandom_range(0, 255));
        len = $urandom_range(4, 10);
      end
      5: begin
        op = $urandom_range(0, 1) ? 8'hAD : 8'h8C;
        len = $urandom_range(4, 15);
        while (len >= 8 && len % 4 == 0) len = $urandom_range(4, 15);
      end
      6: begin
        op = 8'h4D;
        len = $urandom_range(4, 20);
        while (len == 12) len = $urandom_range(4, 20);
      end
      default: begin op = 8'($urandom_range(0, 255)); len = $urandom_range(0, 3); end
    endcase
    p.push_back(op);
    p.push_back(8'($urandom_range(0, 255)));
    p.push_back(8'(len));
    p.push_back(8'(len >> 8));
    for (int i = 4; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
    if (kind == 3) begin
      p[8] = 8'($urandom_range(1, 255));
      p[9] = 8'd0; p[10] = 8'd0; p[11] = 8'd0;
    end
    return p;
  endfunction

  initial begin
    byte_q p;
    // reset values
    #2;
    check_val("rst busy", 32'(busy_o), 32'd0);
    check_val("rst tx_valid", 32'(tx_valid_o), 32'd0);
    check_val("rst tx_data", 32'(tx_data_o), 32'd0);
    check_val("rst alu_start", 32'(alu_start_o), 32'd0);
    check_val("rst alu_a", alu_a_o, 32'd0);
    check_val("rst err", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst rx_ready", 32'(rx_ready_o), 32'd1);
    @(posedge clk); #1;

    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_pkt("add2", p, -1);
    p = '{8'h8C, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
          8'h04, 8'h00, 8'h00, 8'h00};
    run_pkt("mul3", p, -1);
    tx_mode = 2;
    run_pkt("mul3 toggle", p, -1);
    tx_mode = 0;
    p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    run_pkt("echo stall", p, 5);
    p = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    run_pkt("bad opcode", p, -1);
    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    run_pkt("add after err", p, -1);
    p = '{8'h4D, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 12; i++) p.push_back(8'(i + 1));
    run_pkt("div len16", p, -1);
    p = '{8'hAD, 8'h00, 8'h02, 8'h00};
    run_pkt("len2", p, -1);
    p = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_pkt("add1", p, -1);
    p = '{8'h4D, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    run_pkt("div", p, -1);

    // reset while waiting on the ALU
    alu_delay_fix = 15;
    start_seen = 0; got_tx = {};
    p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
    send_pkt(p, -1);
    @(posedge clk); @(posedge clk); #3;
    check_val("wait busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    rst_event = 1'b1;
    #1;
    check_val("async busy", 32'(busy_o), 32'd0);
    check_val("async alu_a", alu_a_o, 32'd0);
    check_val("async alu_b", alu_b_o, 32'd0);
    check_val("async alu_op", 32'(alu_op_o), 32'd0);
    check_val("async tx_valid", 32'(tx_valid_o), 32'd0);
    check_val("async rx_ready", 32'(rx_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_val("late done busy", 32'(busy_o), 32'd0);
    check_val("late done tx", 32'(got_tx.size()), 32'd0);
    check_val("late done starts", 32'(start_seen), 32'd1);
    alu_delay_fix = 0;
    p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    run_pkt("echo after rst", p, -1);

    tx_mode = 1;
    for (int k = 0; k < 40; k++) run_pkt("rand", rand_pkt(), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Packet-level sequencer between the UART byte streams and a shared multi-cycle 32-bit ALU in the uart_alu top. It parses the command header from the RX stream and either echoes the payload or collects 32-bit little-endian operands. For arithmetic commands it issues ALU operations over a start/done handshake and returns the 4-byte result on the TX stream.

Parameters:
OpEcho, 8'hEC, opcode: forward payload bytes unchanged
OpAdd, 8'hAD, opcode: sum of N>=1 operands
OpMul, 8'h8C, opcode: product of N>=1 operands
OpDiv, 8'h4D, opcode: quotient of exactly 2 operands

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
rx_data_i  in  8  received byte
rx_valid_i  in  1  rx_data_i valid
rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o
tx_data_o  out  8  byte to transmit
tx_valid_o  out  1  tx_data_o valid; held until accepted
tx_ready_i  in  1  transmitter accepts on tx_valid_o & tx_ready_i
alu_op_o  out  2  0=ADD, 1=MUL, 2=DIV
alu_a_o  out  32  ALU operand A
alu_b_o  out  32  ALU operand B
alu_start_o  out  1  one-cycle ALU start pulse
alu_done_i  in  1  one-cycle pulse; alu_result_i valid in that cycle
alu_result_i  in  32  ALU result
err_o  out  1  one-cycle pulse on malformed packet
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are clk_i and rst_ni.
- Reset values: state=IDLE, tx_valid_o=0, tx_data_o=0, alu_start_o=0, alu_op_o=0, alu_a_o=0, alu_b_o=0, err_o=0, busy_o=0, all counters and accumulator 0. rx_ready_o=1 in the first cycle after reset release.
- Packet format: opcode, reserved byte (ignored), LEN[7:0], LEN[15:8], then payload. LEN is the total byte count including the 4 header bytes.
- Header states: IDLE -> HDR_RSV -> HDR_LEN_LO -> HDR_LEN_HI. Each advances on an accepted byte. rx_ready_o=1 in these states. In HDR_LEN_HI, remaining = LEN-4, and the command is validated.
- Validation (err_o pulses the cycle after LEN[15:8] is accepted):
  - LEN<4: error, go to IDLE.
  - Unknown opcode: error, go to DRAIN.
  - ADD/MUL with LEN<8 or (LEN-4)%4 != 0: error, go to DRAIN.
  - DIV with LEN != 12: error, go to DRAIN.
  - ECHO with LEN==4: go to IDLE, no TX.
- DRAIN: rx_ready_o=1. Discards bytes until remaining reaches 0, then IDLE. No TX output. If remaining is 0 on entry, return to IDLE immediately.
- ECHO: combinational pass-through. tx_data_o=rx_data_i, tx_valid_o=rx_valid_i, rx_ready_o=tx_ready_i. remaining decrements on each transfer; IDLE after the last byte.
- OPND: collects 4 bytes LSB first into an operand register; rx_ready_o=1.
  - First operand: loaded into the accumulator.
  - Subsequent operands: ALU_START.
  - After the last operand's ALU result, or after a single-operand ADD/MUL: TX_RES.
- ALU_START (1 cycle): alu_start_o=1, alu_a_o=acc, alu_b_o=operand, alu_op_o from opcode. Next state ALU_WAIT.
- ALU_WAIT: rx_ready_o=0. alu_a_o, alu_b_o and alu_op_o are held stable until alu_done_i. On alu_done_i, acc<=alu_result_i, then OPND (operands remain) or TX_RES. No timeout. Division-by-zero result is taken as returned.
- TX_RES: sends acc bytes [7:0], [15:8], [23:16], [31:24] from registered tx_data_o and tx_valid_o. Each byte is held until accepted. IDLE after the 4th transfer. rx_ready_o=0 throughout.
- Arithmetic wraps modulo 2^32; only the low 32 bits of MUL are kept.
- Latency: alu_start_o asserts the cycle after the last byte of operand 2 is accepted. The first result byte is valid the cycle after alu_done_i.
- Reset mid-operation (any state): immediate return to reset values. The pending ALU result and the partial packet are discarded.

Test Plan:
- ADD: RX AD 00 0C 00 01 00 00 00 02 00 00 00. ALU model returns 3 after 5 cycles. Expect exactly one alu_start_o with a=1, b=2, op=0, then TX 03 00 00 00.
- MUL with 3 operands: RX 8C 00 10 00 then operands 2, 3, 4 (LE). ALU model returns products. Expect two starts (2*3, 6*4), then TX 18 00 00 00. Repeat with tx_ready_i toggling every cycle; the same bytes must appear and each must be held stable while stalled.
- ECHO: RX EC 00 07 00 41 42 43 with tx_ready_i low for 3 cycles mid-stream. Expect TX 41 42 43, no byte lost or duplicated, then busy_o=0.
- Errors:
  - RX 55 00 06 00 AA BB: one err_o pulse, 2 bytes drained, no TX. A following ADD packet is processed normally.
  - DIV with LEN=0x10: err_o, 12 bytes drained.
  - LEN=0x0002: err_o, direct return to IDLE.
- Single-operand ADD: RX AD 00 08 00 78 56 34 12. Expect no alu_start_o and TX 78 56 34 12.
- Reset during ALU_WAIT: assert rst_ni=0 asynchronously. All outputs reach reset values without a clock edge. A late alu_done_i after reset is ignored. A subsequent ECHO packet works.
